// File: rtl/region_stream_reader.sv
// region_stream_reader
//   Read-side client of a fifobram region port. A command (FIFO-pop or
//   addressed BRAM mode, base address, word count) is latched in IDLE, then
//   `re` requests are issued to the region read channel under a credit rule
//   so every returned word has a guaranteed slot in the local buffer. The
//   buffer is presented downstream as a valid/ready stream with `out_last`.
//
// Ports
//   clk, reset            : rising-edge clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   : command handshake (ready only in IDLE)
//   cmd_fifo/base/length  : command fields, latched at accept
//   re/raddr/rfifobram    : region read request
//   empty/rvalid/rdata    : region FIFO status and read return
//   out_valid/ready/data  : output stream
//   out_last              : final word of the current command
//   busy                  : FSM not in IDLE
//   done                  : one-cycle pulse at command completion
module region_stream_reader #(
  parameter int WIDTH        = 8,
  parameter int LOG2_DEPTH   = 5,
  parameter int READ_LATENCY = 2,
  parameter int LOG2_BUF     = 2,
  parameter int LENGTH_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_fifo,
  input  logic [LOG2_DEPTH-1:0]   cmd_base,
  input  logic [LENGTH_WIDTH-1:0] cmd_length,
  output logic                    re,
  output logic [LOG2_DEPTH-1:0]   raddr,
  output logic [1:0]              rfifobram,
  input  logic                    empty,
  input  logic                    rvalid,
  input  logic [WIDTH-1:0]        rdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned BUF_WORDS    = 1 << LOG2_BUF;
  localparam int          CW           = LOG2_BUF + 1;
  localparam logic [CW:0] CREDIT_LIMIT = (CW + 1)'(BUF_WORDS);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state;

  logic                    lat_fifo;
  logic [LOG2_DEPTH-1:0]   lat_base;
  logic [LENGTH_WIDTH-1:0] lat_length;
  logic [LENGTH_WIDTH-1:0] issued;
  logic [LENGTH_WIDTH-1:0] delivered;
  logic [CW-1:0]           outstanding;
  logic [CW-1:0]           wptr;
  logic [CW-1:0]           rptr;
  logic [WIDTH-1:0]        buf_mem [BUF_WORDS];

  logic [CW-1:0] occupancy;
  logic [CW-1:0] outstanding_next;
  logic [CW-1:0] occupancy_next;
  logic [CW:0]   credit_used;
  logic          capture;
  logic          pop;

  // Pointers carry one extra bit so a full buffer is distinguishable from empty.
  assign occupancy   = wptr - rptr;
  assign credit_used = {1'b0, outstanding} + {1'b0, occupancy};
  // Data returning with nothing outstanding belongs to a command killed by reset.
  assign capture     = rvalid && (outstanding != '0);
  assign pop         = out_valid && out_ready;

  // A read is only issued when its returning word already has a buffer slot.
  assign re = (state == ISSUE) && (issued < lat_length) &&
              (credit_used < CREDIT_LIMIT) && !(lat_fifo && empty);

  assign raddr     = lat_fifo ? '0 : lat_base + issued[LOG2_DEPTH-1:0];
  assign rfifobram = {1'b0, lat_fifo};
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (occupancy != '0);
  assign out_data  = out_valid ? buf_mem[rptr[LOG2_BUF-1:0]] : '0;
  assign out_last  = out_valid && (delivered == lat_length - LENGTH_WIDTH'(1));

  always_comb begin
    outstanding_next = outstanding;
    if (re && !capture)
      outstanding_next = outstanding + CW'(1);
    else if (!re && capture)
      outstanding_next = outstanding - CW'(1);

    occupancy_next = occupancy;
    if (capture && !pop)
      occupancy_next = occupancy + CW'(1);
    else if (!capture && pop)
      occupancy_next = occupancy - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (capture)
      buf_mem[wptr[LOG2_BUF-1:0]] <= rdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      lat_fifo    <= 1'b0;
      lat_base    <= '0;
      lat_length  <= '0;
      issued      <= '0;
      delivered   <= '0;
      outstanding <= '0;
      wptr        <= '0;
      rptr        <= '0;
      done        <= 1'b0;
    end else begin
      done        <= 1'b0;
      outstanding <= outstanding_next;
      if (capture)
        wptr <= wptr + CW'(1);
      if (pop) begin
        rptr      <= rptr + CW'(1);
        delivered <= delivered + LENGTH_WIDTH'(1);
      end
      if (re)
        issued <= issued + LENGTH_WIDTH'(1);

      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            lat_fifo   <= cmd_fifo;
            lat_base   <= cmd_base;
            lat_length <= cmd_length;
            issued     <= '0;
            delivered  <= '0;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (issued == lat_length)
            state <= DRAIN;
        end
        DRAIN: begin
          // Looking at next-cycle counts lets done follow the final pop directly.
          if (outstanding_next == '0 && occupancy_next == '0) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (BUF_WORDS >= READ_LATENCY + 1)
        else $error("local buffer smaller than READ_LATENCY+1 words");
      assert (!(rvalid && outstanding == '0))
        else $warning("rvalid with no read outstanding; word dropped");
      assert (occupancy <= CW'(BUF_WORDS))
        else $error("buffer occupancy above capacity");
    end
  end

endmodule

// File: tb/tb_region_stream_reader.sv
// Bench for region_stream_reader: a region model with fixed read latency,
// a table of commands checked through an expected-word scoreboard, and
// hand-written sequences around reset.
module tb_region_stream_reader;

  localparam int WIDTH        = 8;
  localparam int LOG2_DEPTH   = 5;
  localparam int READ_LATENCY = 2;
  localparam int LOG2_BUF     = 2;
  localparam int LENGTH_WIDTH = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_fifo = 1'b0;
  logic [4:0]  cmd_base = '0;
  logic [31:0] cmd_length = '0;
  logic        re;
  logic [4:0]  raddr;
  logic [1:0]  rfifobram;
  logic        empty = 1'b0;
  logic        rvalid;
  logic [7:0]  rdata;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic        out_last;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  region_stream_reader #(
    .WIDTH(WIDTH), .LOG2_DEPTH(LOG2_DEPTH), .READ_LATENCY(READ_LATENCY),
    .LOG2_BUF(LOG2_BUF), .LENGTH_WIDTH(LENGTH_WIDTH)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_fifo(cmd_fifo), .cmd_base(cmd_base), .cmd_length(cmd_length),
    .re(re), .raddr(raddr), .rfifobram(rfifobram), .empty(empty),
    .rvalid(rvalid), .rdata(rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
  );

  // Region model: BRAM content is a fixed function of address; FIFO pops
  // return an incrementing sequence. Not reset, so reads in flight survive.
  function automatic logic [7:0] mem_word(input logic [4:0] a);
    logic [7:0] w;
    w = {3'b000, a};
    return w * 8'd13 + 8'd5;
  endfunction

  logic       pipe_v [READ_LATENCY] = '{default: 1'b0};
  logic [7:0] pipe_d [READ_LATENCY] = '{default: 8'h00};
  logic [7:0] fifo_seq = 8'h80;

  always @(posedge clk) begin
    pipe_v[0] <= re;
    pipe_d[0] <= rfifobram[0] ? fifo_seq : mem_word(raddr);
    if (re && rfifobram[0])
      fifo_seq <= fifo_seq + 8'd1;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_d[i] <= pipe_d[i-1];
    end
  end
  assign rvalid = pipe_v[READ_LATENCY-1];
  assign rdata  = pipe_d[READ_LATENCY-1];

  typedef struct {
    logic        fifo;
    logic [4:0]  base;
    int unsigned length;
    logic        bp;           // out_ready 1 cycle on, 3 off
    int unsigned empty_hold;   // cycles after accept with empty high
    int unsigned exp_latency;  // accept to first out_valid (0: skip)
    int unsigned exp_span;     // first to last handshake (0: skip)
    int unsigned exp_peak;     // peak words requested but not yet delivered
    int unsigned exp_done;     // accept to done (0: skip)
  } vec_t;

  logic [7:0] exp_data_q [$];
  logic       exp_last_q [$];
  logic [4:0] exp_addr_q [$];
  logic       exp_fifo = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cyc      = 0;
  int          re_n, hs_n, done_n, peak, re_while_empty;
  int unsigned first_valid_cyc, first_hs_cyc, last_hs_cyc, done_cyc;
  bit          seen_valid, seen_hs;
  logic        hold_prev;
  logic [7:0]  hold_data;
  logic        hold_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail(input string name, input string what);
    n_checks++;
    $display("FAIL %s: %s", name, what);
  endtask

  task automatic clear_stats();
    re_n = 0; hs_n = 0; done_n = 0; peak = 0; re_while_empty = 0;
    first_valid_cyc = 0; first_hs_cyc = 0; last_hs_cyc = 0; done_cyc = 0;
    seen_valid = 0; seen_hs = 0; hold_prev = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_re"},        re,        0);
    check({tag, "_raddr"},     raddr,     0);
    check({tag, "_rfifobram"}, rfifobram, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"},  out_data,  0);
    check({tag, "_out_last"},  out_last,  0);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_done"},      done,      0);
  endtask

  // Called at a negedge after inputs are set; observes this cycle, then
  // advances to the next negedge.
  task automatic step();
    logic [7:0] ed;
    logic       el;
    logic [4:0] ea;
    #1;
    if (!reset) begin
      if (re) begin
        re_n++;
        if (exp_addr_q.size() == 0) fail("unexpected_re", "re asserted with no read expected");
        else begin
          ea = exp_addr_q.pop_front();
          check("raddr", raddr, ea);
          check("rfifobram", rfifobram, {1'b0, exp_fifo});
        end
        if (exp_fifo && empty) re_while_empty++;
      end
      if (out_valid && !seen_valid) begin
        seen_valid = 1;
        first_valid_cyc = cyc;
      end
      if (hold_prev) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, hold_data);
        check("hold_last", out_last, hold_last);
      end
      hold_prev = out_valid && !out_ready;
      hold_data = out_data;
      hold_last = out_last;
      if (out_valid && out_ready) begin
        hs_n++;
        if (!seen_hs) begin
          seen_hs = 1;
          first_hs_cyc = cyc;
        end
        if (exp_data_q.size() == 0) fail("unexpected_word", "stream word with none expected");
        else begin
          ed = exp_data_q.pop_front();
          el = exp_last_q.pop_front();
          check("out_data", out_data, ed);
          check("out_last", out_last, el);
        end
        if (out_last) last_hs_cyc = cyc;
      end
      if (done) begin
        done_n++;
        done_cyc = cyc;
        check("done_cmd_ready", cmd_ready, 1);
        check("done_busy", busy, 0);
      end
      if (re_n - hs_n > peak) peak = re_n - hs_n;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_cmd(input vec_t v, input string tag);
    logic [4:0]  a;
    logic [7:0]  f0;
    int unsigned acc;
    clear_stats();
    exp_fifo = v.fifo;
    f0 = fifo_seq;
    for (int unsigned i = 0; i < v.length; i++) begin
      a = v.base + 5'(i);
      exp_addr_q.push_back(v.fifo ? 5'd0 : a);
      exp_data_q.push_back(v.fifo ? f0 + 8'(i) : mem_word(a));
      exp_last_q.push_back(i == v.length - 1);
    end
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    cmd_valid  = 1'b1;
    cmd_fifo   = v.fifo;
    cmd_base   = v.base;
    cmd_length = v.length;
    out_ready  = 1'b1;
    empty      = (v.empty_hold != 0);
    acc = cyc;
    step();
    // Scramble the command inputs to show the fields were latched.
    cmd_valid  = 1'b0;
    cmd_fifo   = ~v.fifo;
    cmd_base   = ~v.base;
    cmd_length = '0;
    for (int unsigned k = 1; k < 300 && done_n == 0; k++) begin
      out_ready = v.bp ? (k % 4 == 0) : 1'b1;
      empty     = (v.empty_hold != 0) && (k <= v.empty_hold);
      step();
    end
    out_ready = 1'b1;
    empty     = 1'b0;
    repeat (3) step();
    check({tag, "_done_pulses"}, done_n, 1);
    check({tag, "_re_count"}, re_n, v.length);
    check({tag, "_words"}, hs_n, v.length);
    check({tag, "_words_left"}, exp_data_q.size(), 0);
    check({tag, "_peak_inflight"}, peak, v.exp_peak);
    check({tag, "_re_while_empty"}, re_while_empty, 0);
    if (v.length != 0) check({tag, "_done_after_last"}, done_cyc, last_hs_cyc + 1);
    if (v.exp_latency != 0) check({tag, "_latency"}, first_valid_cyc - acc, v.exp_latency);
    if (v.exp_span != 0) check({tag, "_span"}, last_hs_cyc - first_hs_cyc, v.exp_span);
    if (v.exp_done != 0) check({tag, "_done_time"}, done_cyc - acc, v.exp_done);
    exp_data_q.delete();
    exp_last_q.delete();
    exp_addr_q.delete();
  endtask

  vec_t vecs [6];
  vec_t post;

  initial begin
    //            fifo  base    len bp    hold lat span peak done
    vecs[0] = '{1'b0, 5'd3,  8,  1'b0, 0,   4,  7,   3,   12};  // BRAM burst
    vecs[1] = '{1'b0, 5'd30, 4,  1'b0, 0,   4,  3,   3,   8};   // wrap-around
    vecs[2] = '{1'b0, 5'd5,  16, 1'b1, 0,   4,  0,   4,   0};   // backpressure
    vecs[3] = '{1'b1, 5'd9,  5,  1'b0, 6,   10, 4,   3,   15};  // FIFO with empty
    vecs[4] = '{1'b0, 5'd7,  0,  1'b0, 0,   0,  0,   0,   3};   // zero length
    vecs[5] = '{1'b0, 5'd31, 1,  1'b0, 0,   4,  0,   1,   5};   // single word
    post    = '{1'b0, 5'd12, 3,  1'b0, 0,   4,  2,   3,   7};

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    step();

    for (int i = 0; i < 6; i++) run_cmd(vecs[i], $sformatf("vec%0d", i));

    // Reset while two reads are in flight.
    clear_stats();
    exp_fifo = 1'b0;
    exp_addr_q.push_back(5'd0);
    exp_addr_q.push_back(5'd1);
    cmd_valid  = 1'b1;
    cmd_fifo   = 1'b0;
    cmd_base   = 5'd0;
    cmd_length = 8;
    out_ready  = 1'b0;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    check("midrst_busy", busy, 1);
    check("midrst_re_before", re_n, 2);
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    exp_addr_q.delete();
    clear_stats();
    repeat (6) step();
    check("midrst_no_valid", seen_valid, 0);
    check("midrst_no_re", re_n, 0);
    check("midrst_no_done", done_n, 0);
    run_cmd(post, "postrst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
